// File: rtl/demux_1to16_frame_pkg.sv
// Shared definitions for the 1-to-16 framed demultiplexer and its 16:1 selector counterpart.
package demux_1to16_frame_pkg;

  localparam int NUM_LANES = 16;
  localparam int SEL_W     = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } frame_state_e;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    lane_onehot      = '0;
    lane_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_1to16_frame_if.sv
// Handshake, lane-select and lane-parallel output bundle of the framed demultiplexer.
interface demux_1to16_frame_if
  import demux_1to16_frame_pkg::*;
#(
  parameter int size = 4
);
  logic [size-1:0]           in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      auto_mode;
  logic [SEL_W-1:0]          in_sel;
  logic                      frame_ack;
  logic [NUM_LANES*size-1:0] out_bus;
  logic [NUM_LANES-1:0]      out_valid;
  logic [NUM_LANES-1:0]      lane_strobe;
  logic                      frame_done;
  logic [SEL_W-1:0]          cur_ptr;

  modport master (
    output in_data, in_valid, auto_mode, in_sel, frame_ack,
    input  in_ready, out_bus, out_valid, lane_strobe, frame_done, cur_ptr
  );

  modport slave (
    input  in_data, in_valid, auto_mode, in_sel, frame_ack,
    output in_ready, out_bus, out_valid, lane_strobe, frame_done, cur_ptr
  );
endinterface

// File: rtl/demux_lane_bank.sv
// Sixteen lane registers plus their per-lane "written since frame start" flags.
module demux_lane_bank
  import demux_1to16_frame_pkg::*;
#(
  parameter int size = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [NUM_LANES-1:0]      lane_oh_i,
  input  logic [size-1:0]           data_i,
  input  logic                      clr_i,
  output logic [NUM_LANES*size-1:0] bus_o,
  output logic [NUM_LANES-1:0]      valid_o
);

  logic [NUM_LANES*size-1:0] bus_q, bus_d;
  logic [NUM_LANES-1:0]      valid_q, valid_d;

  always_comb begin
    bus_d   = bus_q;
    valid_d = valid_q;
    if (clr_i) begin
      // Data survives a frame release; only the freshness flags are dropped.
      valid_d = '0;
    end else if (we_i) begin
      valid_d = valid_q | lane_oh_i;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_oh_i[k]) bus_d[k*size +: size] = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q   <= '0;
      valid_q <= '0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
    end
  end

  assign bus_o   = bus_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_1to16_frame.sv
// Framed 1-to-16 demultiplexer: FILL accepts words into lanes, HOLD stalls until frame_ack.
module demux_1to16_frame
  import demux_1to16_frame_pkg::*;
#(
  parameter int size = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  demux_1to16_frame_if.slave  bus
);

  frame_state_e         state_q, state_d;
  logic [SEL_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 in_ready_q, in_ready_d;
  logic [NUM_LANES-1:0] strobe_q, strobe_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 clr;
  logic                 complete;
  logic [SEL_W-1:0]     lane_idx;
  logic [NUM_LANES-1:0] lane_oh;
  logic [NUM_LANES-1:0] valid_w;

  assign accept   = bus.in_valid && in_ready_q;
  assign lane_idx = bus.auto_mode ? wr_ptr_q : bus.in_sel;
  assign lane_oh  = lane_onehot(lane_idx);
  assign complete = ((valid_w | lane_oh) == {NUM_LANES{1'b1}});

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    strobe_d = '0;
    done_d   = 1'b0;
    clr      = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          strobe_d = lane_oh;
          if (bus.auto_mode) wr_ptr_d = wr_ptr_q + 1'b1;
          if (complete) begin
            done_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.frame_ack) begin
          state_d  = FILL;
          wr_ptr_d = '0;
          clr      = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    // Registered ready tracks the next state so it drops with the completing strobe.
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      strobe_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      in_ready_q <= in_ready_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
    end
  end

  demux_lane_bank #(.size(size)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (accept),
    .lane_oh_i (lane_oh),
    .data_i    (bus.in_data),
    .clr_i     (clr),
    .bus_o     (bus.out_bus),
    .valid_o   (valid_w)
  );

  assign bus.out_valid   = valid_w;
  assign bus.in_ready    = in_ready_q;
  assign bus.lane_strobe = strobe_q;
  assign bus.frame_done  = done_q;
  assign bus.cur_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_demux_1to16_frame.sv
// Directed bench for demux_1to16_frame: vector table plus hand-written frame corner sequences.
module tb_demux_1to16_frame;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  demux_1to16_frame_if #(.size(4)) dif ();

  demux_1to16_frame #(.size(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        auto_m;
    logic [3:0]  sel;
    logic [3:0]  data;
    logic        ack;
    logic        exp_rdy;
    logic [15:0] exp_strb;
    logic [15:0] exp_ov;
    logic        exp_done;
    logic [3:0]  exp_ptr;
    logic [63:0] exp_bus;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic a, input logic [3:0] s,
                       input logic [3:0] d, input logic k);
    dif.in_valid  = v;
    dif.auto_mode = a;
    dif.in_sel    = s;
    dif.in_data   = d;
    dif.frame_ack = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " bus"},    dif.out_bus, 64'h0);
    chk({tag, " ov"},     {48'h0, dif.out_valid}, 64'h0);
    chk({tag, " strb"},   {48'h0, dif.lane_strobe}, 64'h0);
    chk({tag, " done"},   {63'h0, dif.frame_done}, 64'h0);
    chk({tag, " ptr"},    {60'h0, dif.cur_ptr}, 64'h0);
    chk({tag, " rdy"},    {63'h0, dif.in_ready}, 64'h0);
  endtask

  task automatic add(input logic v, input logic a, input logic [3:0] s, input logic [3:0] d,
                     input logic k, input logic r, input logic [15:0] st, input logic [15:0] ov,
                     input logic dn, input logic [3:0] p, input logic [63:0] b);
    vec_t e;
    e.vld = v; e.auto_m = a; e.sel = s; e.data = d; e.ack = k;
    e.exp_rdy = r; e.exp_strb = st; e.exp_ov = ov; e.exp_done = dn;
    e.exp_ptr = p; e.exp_bus = b;
    tbl.push_back(e);
  endtask

  // Async reset entry and release away from the clock edge, then wait for ready.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk({tag, " rdy after release"}, {63'h0, dif.in_ready}, 64'h1);
  endtask

  initial begin
    logic [63:0] mb;
    logic [15:0] ov;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 1, 0, 0, 0);

    // Frame 1: sixteen auto writes of 0..F
    mb = 64'h0;
    for (int k = 0; k < 16; k++) begin
      mb[k*4 +: 4] = 4'(k);
      ov = 16'((32'h1 << (k + 1)) - 1);
      add(1, 1, 0, 4'(k), 0, (k != 15), 16'(32'h1 << k), ov, (k == 15), 4'((k + 1) % 16), mb);
    end
    // HOLD: writes are ignored for three cycles, then release
    for (int k = 0; k < 3; k++)
      add(1, 1, 0, 4'h5, 0, 0, 16'h0, 16'hFFFF, 0, 4'h0, 64'hFEDCBA9876543210);
    add(0, 1, 0, 4'h0, 1, 1, 16'h0, 16'h0, 0, 4'h0, 64'hFEDCBA9876543210);
    // Manual writes to lanes 3, 3, 7
    add(1, 0, 4'd3, 4'hA, 0, 1, 16'h0008, 16'h0008, 0, 4'h0, 64'hFEDCBA987654A210);
    add(1, 0, 4'd3, 4'hB, 0, 1, 16'h0008, 16'h0008, 0, 4'h0, 64'hFEDCBA987654B210);
    add(1, 0, 4'd7, 4'hC, 0, 1, 16'h0080, 16'h0088, 0, 4'h0, 64'hFEDCBA98C654B210);
    // frame_ack in FILL has no effect
    add(0, 0, 4'd0, 4'h0, 1, 1, 16'h0000, 16'h0088, 0, 4'h0, 64'hFEDCBA98C654B210);

    step();
    step();
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy before first edge", {63'h0, dif.in_ready}, 64'h0);
    step();
    chk("rdy one cycle after release", {63'h0, dif.in_ready}, 64'h1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].auto_m, tbl[i].sel, tbl[i].data, tbl[i].ack);
      step();
      chk($sformatf("vec%0d rdy", i),  {63'h0, dif.in_ready},    {63'h0, tbl[i].exp_rdy});
      chk($sformatf("vec%0d strb", i), {48'h0, dif.lane_strobe}, {48'h0, tbl[i].exp_strb});
      chk($sformatf("vec%0d ov", i),   {48'h0, dif.out_valid},   {48'h0, tbl[i].exp_ov});
      chk($sformatf("vec%0d done", i), {63'h0, dif.frame_done},  {63'h0, tbl[i].exp_done});
      chk($sformatf("vec%0d ptr", i),  {60'h0, dif.cur_ptr},     {60'h0, tbl[i].exp_ptr});
      chk($sformatf("vec%0d bus", i),  dif.out_bus,              tbl[i].exp_bus);
    end

    // Mixed modes: 5 auto writes, then manual lanes 5..15
    do_reset("mix reset");
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 4'hF, 4'(k + 8), 0);
      step();
      chk($sformatf("mix auto%0d strb", k), {48'h0, dif.lane_strobe}, {48'h0, 16'(32'h1 << k)});
      chk($sformatf("mix auto%0d ptr", k),  {60'h0, dif.cur_ptr}, {60'h0, 4'(k + 1)});
    end
    for (int l = 5; l < 16; l++) begin
      drive(1, 0, 4'(l), 4'(l), 0);
      step();
      chk($sformatf("mix man%0d ptr", l),  {60'h0, dif.cur_ptr}, 64'h5);
      chk($sformatf("mix man%0d strb", l), {48'h0, dif.lane_strobe}, {48'h0, 16'(32'h1 << l)});
      chk($sformatf("mix man%0d done", l), {63'h0, dif.frame_done}, {63'h0, (l == 15)});
      chk($sformatf("mix man%0d rdy", l),  {63'h0, dif.in_ready}, {63'h0, (l != 15)});
    end
    chk("mix bus", dif.out_bus, 64'hFEDCBA98765CBA98);
    drive(0, 1, 0, 0, 1);
    step();
    chk("mix ack rdy", {63'h0, dif.in_ready}, 64'h1);
    chk("mix ack ov",  {48'h0, dif.out_valid}, 64'h0);
    chk("mix ack ptr", {60'h0, dif.cur_ptr}, 64'h0);

    // frame_ack high during the completing write must not release the frame
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      drive(1, 1, 0, 4'h1, 0);
      step();
    end
    drive(1, 1, 0, 4'h1, 1);
    step();
    chk("ackfill done", {63'h0, dif.frame_done}, 64'h1);
    chk("ackfill rdy",  {63'h0, dif.in_ready}, 64'h0);
    chk("ackfill strb", {48'h0, dif.lane_strobe}, 64'h8000);
    drive(0, 1, 0, 0, 0);
    step();
    chk("ackfill hold rdy", {63'h0, dif.in_ready}, 64'h0);
    chk("ackfill hold ov",  {48'h0, dif.out_valid}, 64'hFFFF);
    chk("ackfill hold done", {63'h0, dif.frame_done}, 64'h0);
    drive(0, 1, 0, 0, 1);
    step();
    chk("ackfill rel rdy", {63'h0, dif.in_ready}, 64'h1);
    chk("ackfill rel ov",  {48'h0, dif.out_valid}, 64'h0);
    chk("ackfill rel bus", dif.out_bus, 64'h1111111111111111);

    // Reset mid-frame after 9 auto writes
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 0, 4'h3, 0);
      step();
    end
    chk("mid ptr", {60'h0, dif.cur_ptr}, 64'h9);
    do_reset("mid reset");
    drive(1, 1, 0, 4'h7, 0);
    step();
    chk("post reset strb", {48'h0, dif.lane_strobe}, 64'h0001);
    chk("post reset ptr",  {60'h0, dif.cur_ptr}, 64'h1);
    chk("post reset ov",   {48'h0, dif.out_valid}, 64'h0001);
    chk("post reset bus",  dif.out_bus, 64'h7);
    drive(0, 1, 0, 0, 0);
    step();
    chk("post reset strb clr", {48'h0, dif.lane_strobe}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
